// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the fetched word for decode with a
// valid/ready handshake, and handles redirects, misaligned-target traps and halting.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] HALT_WORD    = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {StInit, StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        misalign_d    = 1'b0;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StInit: begin
                state_d = StRun;
            end
            StRun, StHalted: begin
                if (redirect_valid) begin
                    // Redirect flushes the fetch register even under backpressure.
                    if_valid_d = 1'b0;
                    state_d    = StRun;
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_d = redirect_target;
                    end else begin
                        pc_d       = TRAP_VECTOR;
                        misalign_d = 1'b1;
                    end
                end else if (state_q == StRun) begin
                    if (!if_valid_q || id_ready) begin
                        if_instr_d    = instruction;
                        if_pc_d       = pc_q;
                        if_valid_d    = 1'b1;
                        fetch_count_d = fetch_count_q + 32'd1;
                        if (instruction == HALT_WORD) begin
                            state_d = StHalted;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end else if (if_valid_q && id_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StInit;
            pc_q          <= RESET_VECTOR;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_instr_q    <= 32'd0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc           = pc_q;
    assign if_valid     = if_valid_q;
    assign if_pc        = if_pc_q;
    assign if_instr     = if_instr_q;
    assign halted       = (state_q == StHalted);
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a behavioural model predicts the outputs
// after every edge and a negedge monitor pops and compares them.
module tb_fetch_unit;

    localparam logic [31:0] ResetVec = 32'h0000_0000;
    localparam logic [31:0] TrapVec  = 32'h0000_0100;
    localparam logic [31:0] HaltWord = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    assign instruction = mem[pc[9:2]];

    fetch_unit #(
        .RESET_VECTOR(ResetVec),
        .TRAP_VECTOR (TrapVec),
        .HALT_WORD   (HaltWord)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instruction    (instruction),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic        hlt;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    // Reference model: "started" is false only for the single post-reset cycle.
    bit          m_started;
    bit          m_halted;
    logic [31:0] m_pc;
    bit          m_vld;
    logic [31:0] m_ipc;
    logic [31:0] m_ins;
    bit          m_mis;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc", pc, e.pc);
            check("if_valid", {31'd0, if_valid}, {31'd0, e.vld});
            check("if_pc", if_pc, e.ipc);
            check("if_instr", if_instr, e.ins);
            check("halted", {31'd0, halted}, {31'd0, e.hlt});
            check("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            check("fetch_count", fetch_count, e.cnt);
        end
    end

    task automatic model_reset();
        m_started = 0;
        m_halted  = 0;
        m_pc      = ResetVec;
        m_vld     = 0;
        m_ipc     = 0;
        m_ins     = 0;
        m_mis     = 0;
        m_cnt     = 0;
    endtask

    // Called at negedge+1: drive inputs, predict the state after the next edge, push it.
    task automatic step(input bit red, input logic [31:0] tgt, input bit rdy);
        logic [31:0] word;
        exp_t x;
        redirect_valid  = red;
        redirect_target = tgt;
        id_ready        = rdy;
        m_mis = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (red) begin
            m_vld    = 0;
            m_halted = 0;
            if (tgt % 4 == 0) begin
                m_pc = tgt;
            end else begin
                m_pc  = TrapVec;
                m_mis = 1;
            end
        end else if (m_halted) begin
            if (rdy) m_vld = 0;
        end else if (!m_vld || rdy) begin
            word  = mem[m_pc[9:2]];
            m_ins = word;
            m_ipc = m_pc;
            m_vld = 1;
            m_cnt = m_cnt + 1;
            if (word == HaltWord) m_halted = 1;
            else m_pc = m_pc + 4;
        end
        x.pc = m_pc; x.vld = m_vld; x.ipc = m_ipc; x.ins = m_ins;
        x.hlt = m_halted; x.mis = m_mis; x.cnt = m_cnt;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst pc", pc, ResetVec);
        check("rst if_valid", {31'd0, if_valid}, 32'd0);
        check("rst if_pc", if_pc, 32'd0);
        check("rst if_instr", if_instr, 32'd0);
        check("rst halted", {31'd0, halted}, 32'd0);
        check("rst misalign_err", {31'd0, misalign_err}, 32'd0);
        check("rst fetch_count", fetch_count, 32'd0);
    endtask

    // Called at negedge+1, i.e. between rising edges.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_mem(input int halt_odds);
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom();
            if (mem[i] == HaltWord) mem[i] = mem[i] ^ 32'h100;
            if (halt_odds != 0 && $urandom_range(0, halt_odds - 1) == 0) mem[i] = HaltWord;
        end
    endtask

    initial begin
        fill_mem(0);
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential fetch, then backpressure while if_pc=4.
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        // Aligned redirect under backpressure.
        step(0, 0, 0);
        step(1, 32'h40, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);

        // Misaligned redirect.
        step(1, 32'h42, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);

        // Halt at address 8, then resume via redirect.
        mem[2] = HaltWord;
        step(1, 32'h0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(1, 32'h0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1);

        // PC wrap from the top of the address space.
        step(1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);

        // Async reset with if_valid high.
        mid_reset();

        fill_mem(12);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] tgt;
            bit red;
            if ($urandom_range(0, 149) == 0) begin
                mid_reset();
            end
            red = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0:       tgt = {$urandom()} | 32'h1;
                1:       tgt = 32'hFFFF_FFFC;
                default: tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            step(red, tgt, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
